// File: rtl/mlp_r_stream_wrapper.sv
// Stream front/back end for the approximate MLP regressor core: packs serial
// features into the flat core input bus, then rounds and saturates the core output.
module mlp_r_stream_wrapper #(
    parameter int WIDTH_A    = 4,
    parameter int NUM_A      = 21,
    parameter int OUTWIDTH   = 22,
    parameter int FRAC       = 16,
    parameter int MAX_CLASS  = 3,
    parameter int CLS_W      = 2,
    parameter int SETTLE     = 2,
    parameter int ROUND_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH_A-1:0]       in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_A*WIDTH_A-1:0] core_inp,
    input  logic [OUTWIDTH-1:0]      core_out,
    output logic [CLS_W-1:0]         out_class,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IP_W  = OUTWIDTH - FRAC;
    localparam logic [FRAC-1:0] HALF  = FRAC'(1) << (FRAC - 1);
    localparam logic [IP_W:0]   MAX_R = (IP_W + 1)'(MAX_CLASS);

    // state     | meaning
    // ST_LOAD   | accepting features into core_inp
    // ST_SETTLE | core inputs frozen, waiting for the core output to settle
    // ST_OUT    | result presented, waiting for downstream handshake
    typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_A*WIDTH_A-1:0] inp_q, inp_d;
    logic [CLS_W-1:0]         class_q, class_d;
    logic                     sat_q, sat_d;
    logic                     valid_q, valid_d;

    logic [IP_W-1:0]  ip;
    logic [FRAC-1:0]  fr;
    logic             round_up;
    logic [IP_W:0]    r;
    logic             r_sat;
    logic [CLS_W-1:0] r_class;

    // One extra bit on r keeps ip all-ones plus a round-up from wrapping to 0.
    always_comb begin
        ip       = core_out[OUTWIDTH-1:FRAC];
        fr       = core_out[FRAC-1:0];
        round_up = 1'b0;
        if (ROUND_MODE == 1) round_up = (fr > HALF);
        if (ROUND_MODE == 2) round_up = (fr >= HALF);
        r       = {1'b0, ip} + (IP_W + 1)'(round_up);
        r_sat   = (r > MAX_R);
        r_class = r_sat ? CLS_W'(MAX_CLASS) : r[CLS_W-1:0];
    end

    assign in_ready  = (state_q == ST_LOAD) && !rst;
    assign core_inp  = inp_q;
    assign out_class = class_q;
    assign out_sat   = sat_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            class_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            inp_q   <= inp_d;
            class_q <= class_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        inp_d   = inp_q;
        class_d = class_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    inp_d[idx_q*WIDTH_A +: WIDTH_A] = in_data;
                    if (idx_q == IDX_W'(NUM_A - 1)) begin
                        idx_d   = '0;
                        cnt_d   = CNT_W'(SETTLE - 1);
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    class_d = r_class;
                    sat_d   = r_sat;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

endmodule

// File: tb/tb_mlp_r_stream_wrapper.sv
// Bench for mlp_r_stream_wrapper: three instances (truncate, half-down, half-up)
// share one stimulus stream and are checked against an arithmetic rounding model.
module tb_mlp_r_stream_wrapper;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic [21:0] core_out;

    logic        rdy   [3];
    logic [83:0] cinp  [3];
    logic [1:0]  cls   [3];
    logic        sat   [3];
    logic        valid [3];

    logic [3:0]  frame [21];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        mlp_r_stream_wrapper #(.SETTLE(SETTLE), .ROUND_MODE(m)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (rdy[m]),
            .core_inp (cinp[m]),
            .core_out (core_out),
            .out_class(cls[m]),
            .out_sat  (sat[m]),
            .out_valid(valid[m]),
            .out_ready(out_ready)
        );
    end

    // Reference: value = core_out / 2^16, rounded per mode, clipped at 3.
    function automatic logic [2:0] model(input int mode, input logic [21:0] v);
        int ip, fr, r;
        ip = int'(v >> 16);
        fr = int'(v & 22'h00FFFF);
        r  = ip;
        if (mode == 1 && fr > 32768) r = r + 1;
        if (mode == 2 && fr >= 32768) r = r + 1;
        if (r > 3) return {1'b1, 2'd3};
        return {1'b0, r[1:0]};
    endfunction

    task automatic run_frame(input logic [21:0] cv, input bit gaps, input int hold,
                             input bit early_ready);
        logic [83:0] exp_inp;
        logic [2:0]  exp_r;
        logic [88:0] snap;
        int k;
        core_out  = cv;
        out_ready = early_ready;
        exp_inp   = '0;
        for (int i = 0; i < 21; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_data  = frame[i];
            in_valid = 1'b1;
            exp_inp[i*4 +: 4] = frame[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 4'($urandom);

        k = 0;
        while (valid[1] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (k + 1 !== SETTLE + 1)
            $display("FAIL latency: got %0d cycles, expected %0d", k + 1, SETTLE + 1);
        else n_pass++;

        for (int m = 0; m < 3; m++) begin
            exp_r = model(m, cv);
            n_checks++;
            if ({valid[m], sat[m], cls[m]} !== {1'b1, exp_r})
                $display("FAIL result mode%0d core_out=%h: got valid=%b sat=%b class=%0d, expected 1 %b %0d",
                         m, cv, valid[m], sat[m], cls[m], exp_r[2], exp_r[1:0]);
            else n_pass++;
            n_checks++;
            if (cinp[m] !== exp_inp)
                $display("FAIL packing mode%0d: got %h, expected %h", m, cinp[m], exp_inp);
            else n_pass++;
        end
        n_checks++;
        if ({cinp[1][3:0], cinp[1][83:80]} !== {frame[0], frame[20]})
            $display("FAIL end_slices: got %h/%h, expected %h/%h",
                     cinp[1][3:0], cinp[1][83:80], frame[0], frame[20]);
        else n_pass++;
        n_checks++;
        if (rdy[1] !== 1'b0) $display("FAIL in_ready_in_out: got %b, expected 0", rdy[1]);
        else n_pass++;

        snap = {valid[1], sat[1], cls[1], cinp[1]};
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = 4'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({valid[1], sat[1], cls[1], cinp[1], rdy[1]} !== {snap, 1'b0})
                $display("FAIL hold cycle %0d: got %h, expected %h", h,
                         {valid[1], sat[1], cls[1], cinp[1], rdy[1]}, {snap, 1'b0});
            else n_pass++;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({valid[0], valid[1], valid[2], rdy[1]} !== 4'b0001)
            $display("FAIL handshake: got valid=%b%b%b in_ready=%b, expected 000 1",
                     valid[0], valid[1], valid[2], rdy[1]);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_out = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({rdy[m], valid[m], sat[m], cls[m], cinp[m]} !== '0)
                $display("FAIL reset_state mode%0d: got rdy=%b valid=%b sat=%b class=%0d inp=%h, expected all 0",
                         m, rdy[m], valid[m], sat[m], cls[m], cinp[m]);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy[1] !== 1'b1) $display("FAIL ready_after_reset: got %b, expected 1", rdy[1]);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [21:0] vals[6] = '{22'h028000, 22'h028001, 22'h017FFF,
                                 22'h000000, 22'h050000, 22'h3FFFFF};
        for (int i = 0; i < 21; i++) frame[i] = 4'(i % 16);
        run_frame(vals[0], 1'b0, 5, 1'b0);
        for (int v = 1; v < 6; v++) begin
            for (int i = 0; i < 21; i++) frame[i] = 4'($urandom);
            run_frame(vals[v], 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_random;
        logic [21:0] cv;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 21; i++) frame[i] = 4'($urandom);
            cv = {6'($urandom_range(0, 5)), 16'($urandom)};
            if (n % 3 == 0) cv[15:0] = 16'h8000;
            run_frame(cv, 1'b1, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 21; i++) frame[i] = 4'($urandom);
            run_frame({6'($urandom_range(0, 4)), 16'($urandom)}, 1'b0, 0, 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int extra;
        for (int i = 0; i < 10; i++) begin
            in_data = 4'($urandom_range(1, 15)); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rdy[1], valid[1], cinp[1]} !== '0)
            $display("FAIL reset_mid_frame: got rdy=%b valid=%b inp=%h, expected 0 0 0",
                     rdy[1], valid[1], cinp[1]);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 21; i++) frame[i] = 4'($urandom);
        run_frame(22'h020000, 1'b0, 0, 1'b0);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (valid[1] !== 1'b0) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL single_result: got %0d extra valid cycles, expected 0", extra);
        else n_pass++;

        for (int i = 0; i < 21; i++) begin
            in_data = 4'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        core_out = 22'h030000;
        k = 0;
        while (valid[1] !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({valid[1], sat[1], cls[1], rdy[1]} !== 5'b0)
            $display("FAIL reset_mid_out: got valid=%b sat=%b class=%0d rdy=%b, expected 0 0 0 0",
                     valid[1], sat[1], cls[1], rdy[1]);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mlp_r_stream_wrapper.md
Name: mlp_r_stream_wrapper

Overview:
Sequential front/back end for the combinational approximate MLP regressor core. It accepts features one per cycle over a valid/ready stream and packs them into the core's flat input bus. It then waits a fixed settle time and converts the core's unsigned fixed-point output into a saturated integer class. The class is presented on a valid/ready output stream, replacing testbench-side rounding with synthesizable logic.

Parameters:
WIDTH_A, 4, bits per input feature
NUM_A, 21, features per inference frame
OUTWIDTH, 22, width of core regression output
FRAC, 16, fractional bits in core output (FRAC < OUTWIDTH)
MAX_CLASS, 3, upper saturation bound of class result
CLS_W, 2, class output width (must hold MAX_CLASS)
SETTLE, 2, cycles core output is allowed to settle (>=1)
ROUND_MODE, 1, 0 = truncate, 1 = round half down, 2 = round half up

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_data  in  WIDTH_A  feature value
in_valid  in  1  feature valid
in_ready  out  1  wrapper can accept feature
core_inp  out  NUM_A*WIDTH_A  packed features to core
core_out  in  OUTWIDTH  core regression result
out_class  out  CLS_W  rounded, saturated class
out_sat  out  1  saturation occurred for this result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result

Behaviour:
- One clock; reset is asynchronous and active-high on rst. All registers clear on rst assertion.
- Reset values: core_inp=0, out_class=0, out_sat=0, out_valid=0, state=LOAD, idx=0. in_ready is 0 while rst is high.
- in_ready = (state==LOAD) && !rst, combinational from state.
- FSM states are LOAD, SETTLE and OUT.
- LOAD:
  - On in_valid&&in_ready, write in_data into core_inp[idx*WIDTH_A +: WIDTH_A] and increment idx.
  - First accepted feature goes to the lowest slice.
  - On accepting feature NUM_A-1, reset idx to 0, load settle counter with SETTLE-1, and go to SETTLE.
- SETTLE:
  - core_inp is held stable. The counter decrements each cycle.
  - In the cycle the counter is 0, register out_class/out_sat from core_out, set out_valid=1, and go to OUT.
- OUT:
  - out_valid, out_class and out_sat are held stable until out_valid&&out_ready.
  - On that handshake: out_valid drops next cycle and state returns to LOAD.
  - in_ready rises the cycle after the handshake; there is no same-cycle overlap.
- core_inp retains the last frame until overwritten by new features.
- Latency: last feature accepted in cycle N gives out_valid high from cycle N+SETTLE+1.
- Arithmetic:
  - ip = core_out[OUTWIDTH-1:FRAC] (unsigned). fr = core_out[FRAC-1:0]. half = 1<<(FRAC-1).
  - ROUND_MODE 0: r=ip.
  - ROUND_MODE 1: r=ip+1 if fr>half, else ip.
  - ROUND_MODE 2: r=ip+1 if fr>=half, else ip.
  - r is computed in OUTWIDTH-FRAC+1 bits so there is no wrap at ip all-ones.
  - If r>MAX_CLASS: out_class=MAX_CLASS and out_sat=1. Otherwise out_class=r[CLS_W-1:0] and out_sat=0.
  - Saturation applies in all modes and both rounding paths.
- Boundary conditions:
  - in_valid low in LOAD: idx holds; gaps are allowed anywhere in the frame.
  - in_data is ignored outside LOAD.
  - out_ready high before out_valid: no effect.
  - rst mid-frame or mid-OUT: partial frame and pending result are discarded, and the next frame restarts at idx 0.
  - SETTLE=1: the result is captured in the first SETTLE cycle.

Test Plan:
- Defaults (FRAC=16, mode 1), model core_out=0x28000 (2.5) -> out_class=2, out_sat=0; the same frame with ROUND_MODE=2 -> 3; ROUND_MODE=0 -> 2.
- core_out=0x28001, mode 1 -> 3; core_out=0x17FFF -> 1; core_out=0x00000 -> 0.
- core_out=0x50000 (all modes) -> out_class=3, out_sat=1; core_out=0x3FFFFF, mode 2 -> 3, out_sat=1 (no wrap).
- 21 features with values 0..15 cycling, one per cycle:
  - out_valid rises exactly SETTLE+1=3 cycles after the 21st accept.
  - core_inp[3:0] equals the first value and core_inp[83:80] equals the 21st.
- Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, extra in_valid ignored; then out_ready=1 -> out_valid low and in_ready=1 next cycle.
- Assert rst after 10 accepted features, release, send a full 21-feature frame -> one result only, packing starts at slice 0, no stale features from the first frame.
